// File: rtl/div_reconstruct_seq.sv
// Sequential shift-add rebuild of the dividend n_hat = q*d + r, one quotient bit per cycle.
// Optional error accumulator against a reference dividend is built only when DIV_RECON_ERR_ACC_EN is defined.
module div_reconstruct_seq #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] n_hat
`ifdef DIV_RECON_ERR_ACC_EN
  ,
  input  logic [2*WIDTH-1:0] n_ref,
  input  logic               acc_clr,
  output logic [2*WIDTH-1:0] err_abs,
  output logic [ACC_W-1:0]   sq_err_acc,
  output logic [15:0]        sample_cnt
`endif
);

  localparam int NW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_nx;
  logic [WIDTH-1:0] qs;
  logic [NW-1:0]  md;
  logic [NW-1:0]  acc;
  logic [CW-1:0]  cnt;
  logic           last;

  // cnt runs 0..WIDTH-1 for the add/shift steps; the extra cnt==WIDTH cycle publishes acc.
  assign last = (cnt == CW'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qs    <= '0;
      md    <= '0;
      acc   <= '0;
      cnt   <= '0;
      n_hat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            qs  <= q;
            md  <= NW'(d);
            acc <= NW'(r);
            cnt <= '0;
          end
        end
        RUN: begin
          if (last) begin
            n_hat <= acc;
          end else begin
            // Max result is 2^2W - 2^W, so the NW-bit adder never carries out.
            if (qs[0]) acc <= acc + md;
            md  <= md << 1;
            qs  <= qs >> 1;
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_RECON_ERR_ACC_EN
  logic [NW-1:0]   nref_r;
  logic [2*NW-1:0] sq;
  logic [ACC_W:0]  sum;

  always_comb begin
    err_abs = (nref_r >= n_hat) ? (nref_r - n_hat) : (n_hat - nref_r);
    sq      = (2*NW)'(err_abs) * (2*NW)'(err_abs);
    sum     = {1'b0, sq_err_acc} + (ACC_W+1)'(sq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nref_r     <= '0;
      sq_err_acc <= '0;
      sample_cnt <= '0;
    end else begin
      if (state == IDLE && in_valid) nref_r <= n_ref;
      if (acc_clr) begin
        sq_err_acc <= '0;
        sample_cnt <= '0;
      end else if (out_valid && out_ready) begin
        sq_err_acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// Directed and randomized checks of div_reconstruct_seq against plain q*d+r arithmetic.
module tb_div_reconstruct_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q, d, r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] n_hat;
`ifdef DIV_RECON_ERR_ACC_EN
  logic [15:0] n_ref;
  logic        acc_clr;
  logic [15:0] err_abs;
  logic [47:0] sq_err_acc;
  logic [15:0] sample_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_reconstruct_seq #(.WIDTH(8), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .d(d), .r(r), .out_valid(out_valid), .out_ready(out_ready), .n_hat(n_hat)
`ifdef DIV_RECON_ERR_ACC_EN
    , .n_ref(n_ref), .acc_clr(acc_clr), .err_abs(err_abs),
    .sq_err_acc(sq_err_acc), .sample_cnt(sample_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] mq, md, mr);
    int v;
    v = int'(mq) * int'(md) + int'(mr);
    return v[15:0];
  endfunction

  // Present a triple from a negedge, let it be accepted, then scramble the inputs.
  task automatic send(input logic [7:0] tq, td, tr);
    q = tq; d = td; r = tr; in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    q = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
  endtask

  // Full job: hold cycles of backpressure once the result appears.
  task automatic job(input logic [7:0] tq, td, tr, input int hold, input string tag);
    int lat;
    logic [15:0] exp, first;
    exp = model(tq, td, tr);
    out_ready = (hold == 0);
    send(tq, td, tr);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_n_hat"}, n_hat, exp);
    first = n_hat;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      q = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
      @(negedge clk);
      chk({tag, "_hold_n_hat"}, n_hat, first);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [7:0] rq, rd, rr;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; q = '0; d = '0; r = '0;
`ifdef DIV_RECON_ERR_ACC_EN
    n_ref = '0; acc_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_n_hat", n_hat, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DIV_RECON_ERR_ACC_EN
    chk("rst_sq_acc", sq_err_acc, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    n_ref = 16'd130;
    job(8'd12, 8'd10, 8'd3, 0, "err1");
    chk("err1_abs", err_abs, 7);
    chk("err1_sq", sq_err_acc, 49);
    chk("err1_cnt", sample_cnt, 1);
    n_ref = 16'd100;
    job(8'd9, 8'd11, 8'd1, 0, "err2");
    chk("err2_abs", err_abs, 0);
    chk("err2_sq", sq_err_acc, 49);
    chk("err2_cnt", sample_cnt, 2);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("clr_sq", sq_err_acc, 0);
    chk("clr_cnt", sample_cnt, 0);
`endif

    job(8'h0C, 8'h0A, 8'h03, 0, "basic");
    job(8'hFF, 8'hFF, 8'hFE, 0, "max_fe");
    job(8'hFF, 8'hFF, 8'hFF, 0, "max_ff");
    job(8'hFF, 8'hFF, 8'h00, 0, "max_00");
    job(8'hA5, 8'h00, 8'h37, 0, "d_zero");
    job(8'h00, 8'h80, 8'h05, 0, "q_zero");
    job(8'h03, 8'h05, 8'hF0, 0, "r_ge_d");
    job(8'h5A, 8'h3C, 8'h11, 5, "bp");
    job(8'h21, 8'h07, 8'h02, 0, "after_bp");

    // Asynchronous reset while the shift loop is half done.
    out_ready = 1'b1;
    send(8'hC3, 8'h9D, 8'h44);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    job(8'd2, 8'd3, 8'd1, 0, "postrst");

    for (int i = 0; i < 24; i++) begin
      rq = 8'($urandom); rd = 8'($urandom); rr = 8'($urandom);
      job(rq, rd, rr, int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
